branch_hazard_ctrl: RTL and testbench
=====================================

Name: branch_hazard_ctrl

Overview:
- ID-stage control block that sits beside the ID-stage branch forwarding unit and drives the pipeline stall and flush controls for branches resolved in ID.
- Detects operand hazards that forwarding cannot cover:
  - an ALU result still in EX;
  - a load in EX;
  - a load in MEM.
- Holds the branch in ID for the required number of cycles using a small FSM and counter.
- Issues the redirect and the IF/ID flush when a resolved branch is taken.

Parameters:
- CNT_W, 2, width of the stall-remaining counter.
- STATS_W, 32, width of the statistics counters (used only when the optional feature is enabled).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- branch_ID  in  1  valid branch/JALR in ID
- uses_rs2_ID  in  1  instruction reads rs2 (0 for JALR)
- rs1_ID  in  5  source reg 1 in ID
- rs2_ID  in  5  source reg 2 in ID
- taken_ID  in  1  comparator outcome using forwarded operands; valid only when not stalling
- rd_EX  in  5  destination reg in EX
- reg_write_EX  in  1  EX instruction writes rd
- mem_read_EX  in  1  EX instruction is a load
- rd_MEM  in  5  destination reg in MEM
- mem_read_MEM  in  1  MEM instruction is a load
- kill  in  1  higher-priority flush from a later stage (trap/exception)
- pc_write  out  1  1 = PC updates, 0 = hold
- if_id_write  out  1  1 = IF/ID register updates, 0 = hold
- id_ex_bubble  out  1  1 = insert NOP into ID/EX
- if_id_flush  out  1  1 = zero IF/ID (squash wrong-path fetch)
- pc_sel_branch  out  1  1 = next PC is the branch target
- stall_cnt_o  out  STATS_W  total stall cycles (feature-gated)
- taken_cnt_o  out  STATS_W  total taken branches (feature-gated)

Behaviour:
- Clock and reset:
  - Clock is clk.
  - Reset is asynchronous and active-low on rst_n.
  - Reset state: state=RUN, cnt=0, both statistics counters 0.
  - While rst_n=0 the outputs are forced to pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, pc_sel_branch=0.
- Match terms:
  - hitX_EX = reg_write_EX && rd_EX!=0 && rd_EX==rsX.
  - hitX_MEMLD = mem_read_MEM && rd_MEM!=0 && rd_MEM==rsX.
  - rs2 terms count only if uses_rs2_ID=1.
- Stall need, evaluated in RUN with branch_ID=1:
  - need=2 if any hit_EX with mem_read_EX=1;
  - else need=1 if any hit_EX (ALU result) or any hit_MEMLD;
  - else need=0.
- FSM states RUN and STALL:
  - RUN, need=0: stall outputs are inactive; the branch resolves this cycle.
  - RUN, need>0: stall is active this cycle.
    - need=1: stay in RUN; need is re-evaluated next cycle, by which point the producer has advanced into forwardable range.
    - need=2: go to STALL with cnt=1.
  - STALL: stall is active regardless of inputs; cnt decrements; when cnt==0, next state is RUN.
- Stall outputs:
  - pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, pc_sel_branch=0.
- Resolve (RUN, branch_ID=1, need=0):
  - taken_ID=1: pc_sel_branch=1, if_id_flush=1, pc_write=1, if_id_write=1, id_ex_bubble=0. These are combinational, same cycle, and asserted for exactly one cycle per branch.
  - taken_ID=0: all outputs stay at their defaults.
- Defaults (no branch or no hazard): pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, pc_sel_branch=0.
- kill=1 has the highest priority:
  - next state=RUN, cnt=0;
  - this cycle's outputs are defaults, with if_id_flush=1 and pc_sel_branch=0;
  - the later stage owns the PC redirect.
- branch_ID dropping while in STALL (via an upstream kill only) must not corrupt the FSM: STALL finishes its count, then returns to RUN.
- Counter decrement saturates at 0; there is no wrap.

Optional Feature:
- Macro: BRANCH_HAZ_STATS_EN.
- Enabled:
  - stall_cnt_o increments by 1 on every cycle with id_ex_bubble=1 due to stall (kill cycles excluded).
  - taken_cnt_o increments on every resolve cycle with taken_ID=1.
  - Both wrap modulo 2^STATS_W.
- Disabled: no counter registers; stall_cnt_o and taken_cnt_o are tied to 0.

Test Plan:
- Load in EX, no intervening flush. Stimulus: mem_read_EX=1, reg_write_EX=1, rd_EX=5; branch_ID=1, rs1_ID=5. Response: 2 consecutive cycles of pc_write=0, if_id_write=0, id_ex_bubble=1; the third cycle resolves.
- ALU result in EX. Stimulus: reg_write_EX=1, mem_read_EX=0, rd_EX=7; branch rs2_ID=7, uses_rs2_ID=1. Response: exactly 1 stall cycle. Same stimulus with uses_rs2_ID=0: 0 stalls.
- Writer of x0 ignored. Stimulus: rd_EX=0, reg_write_EX=1, rs1_ID=0. Response: no stall.
- Taken branch. Stimulus: branch with no hazard, taken_ID=1. Response: pc_sel_branch=1 and if_id_flush=1 for exactly 1 cycle. With BRANCH_HAZ_STATS_EN, taken_cnt_o goes 0→1.
- kill during STALL. Stimulus: kill=1 in the STALL cycle following a load-in-EX detect. Response: state returns to RUN next cycle, if_id_flush=1, pc_sel_branch=0.
- Reset mid-stall. Stimulus: rst_n=0 asynchronously in STALL. Response: outputs immediately pc_write=1, id_ex_bubble=0; after release, state=RUN and the statistics counters read 0.

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: ID-stage stall/flush control for branches resolved in ID.
// Define BRANCH_HAZ_STATS_EN to enable the stall and taken-branch statistics counters.
module branch_hazard_ctrl #(
  parameter int CNT_W   = 2,
  parameter int STATS_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               branch_ID,
  input  logic               uses_rs2_ID,
  input  logic [4:0]         rs1_ID,
  input  logic [4:0]         rs2_ID,
  input  logic               taken_ID,
  input  logic [4:0]         rd_EX,
  input  logic               reg_write_EX,
  input  logic               mem_read_EX,
  input  logic [4:0]         rd_MEM,
  input  logic               mem_read_MEM,
  input  logic               kill,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               id_ex_bubble,
  output logic               if_id_flush,
  output logic               pc_sel_branch,
  output logic [STATS_W-1:0] stall_cnt_o,
  output logic [STATS_W-1:0] taken_cnt_o
);
  typedef enum logic {RUN, STALL} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             w_hit_ex, w_hit_memld, w_need2, w_need1, w_stall, w_taken;
  always_comb begin
    w_hit_ex    = reg_write_EX && rd_EX != 5'd0 &&
                  (rd_EX == rs1_ID || (uses_rs2_ID && rd_EX == rs2_ID));
    w_hit_memld = mem_read_MEM && rd_MEM != 5'd0 &&
                  (rd_MEM == rs1_ID || (uses_rs2_ID && rd_MEM == rs2_ID));
    w_need2     = w_hit_ex && mem_read_EX;
    w_need1     = !w_need2 && (w_hit_ex || w_hit_memld);
    w_cnt_dec   = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);
    // rst_n gating forces the default outputs combinationally while in reset
    w_stall     = rst_n && !kill &&
                  (r_state == STALL || (branch_ID && (w_need1 || w_need2)));
    w_taken     = rst_n && !kill && r_state == RUN && branch_ID &&
                  !w_need1 && !w_need2 && taken_ID;
    pc_write      = !w_stall;
    if_id_write   = !w_stall;
    id_ex_bubble  = w_stall;
    if_id_flush   = rst_n && (kill || w_taken);
    pc_sel_branch = w_taken;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else if (kill) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else if (r_state == STALL) begin
      r_cnt   <= w_cnt_dec;
      r_state <= (w_cnt_dec == '0) ? RUN : STALL;
    end else if (branch_ID && w_need2) begin
      r_state <= STALL;
      r_cnt   <= CNT_W'(1);
    end
  end
`ifdef BRANCH_HAZ_STATS_EN
  logic [STATS_W-1:0] r_stall_cnt, r_taken_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_taken_cnt <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + STATS_W'(1);
      if (w_taken) r_taken_cnt <= r_taken_cnt + STATS_W'(1);
    end
  end
  assign stall_cnt_o = r_stall_cnt;
  assign taken_cnt_o = r_taken_cnt;
`else
  assign stall_cnt_o = '0;
  assign taken_cnt_o = '0;
`endif
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: scoreboard bench with directed vectors for branch_hazard_ctrl.
module tb_branch_hazard_ctrl;
  logic clk = 1'b1;
  logic rst_n, branch_ID, uses_rs2_ID, taken_ID, reg_write_EX, mem_read_EX, mem_read_MEM, kill;
  logic [4:0] rs1_ID, rs2_ID, rd_EX, rd_MEM;
  logic pc_write, if_id_write, id_ex_bubble, if_id_flush, pc_sel_branch;
  logic [31:0] stall_cnt_o, taken_cnt_o;
  typedef struct {
    logic [4:0]  o;
    logic [31:0] sc;
    logic [31:0] tc;
    string       nm;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  int es = 0, et = 0;
  localparam logic [4:0] DEF = 5'b11000, STL = 5'b00100, TKN = 5'b11011, KIL = 5'b11010;
  branch_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .branch_ID(branch_ID), .uses_rs2_ID(uses_rs2_ID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .taken_ID(taken_ID), .rd_EX(rd_EX),
    .reg_write_EX(reg_write_EX), .mem_read_EX(mem_read_EX), .rd_MEM(rd_MEM),
    .mem_read_MEM(mem_read_MEM), .kill(kill), .pc_write(pc_write),
    .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
    .pc_sel_branch(pc_sel_branch), .stall_cnt_o(stall_cnt_o), .taken_cnt_o(taken_cnt_o)
  );
  always #5 clk = ~clk;
  task automatic clr();
    branch_ID = 0; uses_rs2_ID = 0; rs1_ID = 0; rs2_ID = 0; taken_ID = 0;
    rd_EX = 0; reg_write_EX = 0; mem_read_EX = 0; rd_MEM = 0; mem_read_MEM = 0; kill = 0;
  endtask
  // push this cycle's expectation, then advance to just after the next rising edge
  task automatic cyc(input string nm, input logic [4:0] e);
    exp_t x;
    x.o = e; x.nm = nm;
`ifdef BRANCH_HAZ_STATS_EN
    x.sc = es; x.tc = et;
`else
    x.sc = 0; x.tc = 0;
`endif
    q.push_back(x);
    if (e[2]) es++;
    if (e[0]) et++;
    @(posedge clk); #1;
  endtask
  task automatic ld_detect(input string nm);
    clr(); branch_ID = 1; rs1_ID = 5; rd_EX = 5; reg_write_EX = 1; mem_read_EX = 1;
    cyc(nm, STL);
  endtask
  initial begin : monitor
    exp_t x;
    logic [4:0] a;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        x = q.pop_front();
        a = {pc_write, if_id_write, id_ex_bubble, if_id_flush, pc_sel_branch};
        checks++;
        if (a !== x.o) begin
          errors++;
          $display("FAIL %s outputs: got %b expected %b", x.nm, a, x.o);
        end
        checks++;
        if (stall_cnt_o !== x.sc || taken_cnt_o !== x.tc) begin
          errors++;
          $display("FAIL %s stats: got stall=%0d taken=%0d expected stall=%0d taken=%0d",
                   x.nm, stall_cnt_o, taken_cnt_o, x.sc, x.tc);
        end
      end
    end
  end
  initial begin : driver
    clr(); rst_n = 0;
    @(posedge clk); #1;
    branch_ID = 1; rs1_ID = 5; rd_EX = 5; reg_write_EX = 1; mem_read_EX = 1; kill = 1;
    cyc("reset", DEF);
    rst_n = 1; clr();
    cyc("idle", DEF);
    ld_detect("ld1");
    clr(); branch_ID = 1; rs1_ID = 5;
    cyc("ld2", STL);
    cyc("ld3_resolve", DEF);
    clr(); branch_ID = 1; uses_rs2_ID = 1; rs2_ID = 7; rd_EX = 7; reg_write_EX = 1;
    cyc("alu1", STL);
    clr(); branch_ID = 1; uses_rs2_ID = 1; rs2_ID = 7; taken_ID = 1;
    cyc("alu2_taken", TKN);
    clr();
    cyc("after_taken", DEF);
    branch_ID = 1; rs2_ID = 7; rd_EX = 7; reg_write_EX = 1;
    cyc("alu_no_rs2", DEF);
    clr(); branch_ID = 1; rd_EX = 0; reg_write_EX = 1; mem_read_EX = 1;
    cyc("x0_writer", DEF);
    clr(); branch_ID = 1; rs1_ID = 3; rd_MEM = 3; mem_read_MEM = 1;
    cyc("memld", STL);
    clr(); branch_ID = 1; rs1_ID = 3; taken_ID = 1;
    cyc("memld_taken", TKN);
    clr(); taken_ID = 1;
    cyc("no_branch", DEF);
    ld_detect("kill1");
    clr(); branch_ID = 1; rs1_ID = 5; kill = 1;
    cyc("kill2", KIL);
    clr();
    cyc("kill3_run", DEF);
    ld_detect("drop1");
    clr();
    cyc("drop2_stall", STL);
    cyc("drop3_run", DEF);
    ld_detect("rst1");
    rst_n = 0; es = 0; et = 0; clr(); branch_ID = 1; rs1_ID = 5;
    cyc("rst2_async", DEF);
    rst_n = 1; clr();
    cyc("rst3_run", DEF);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL monitor_timeout: %0d pending, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
